// File: rtl/ifm_chunk_wr_ctrl.sv
// ---------------------------------------------------------------------------
// ifm_chunk_wr_ctrl
//
// Write-side controller for the ping-pong IFM chunk buffer. Accepts a
// valid/ready stream of compressed IFM beats (sparsemap + packed nonzero
// bytes) and registers each beat onto the buffer write port together with
// its beat index and target bank. Chunks alternate between bank 0 and
// bank 1. The controller tracks which banks hold a complete chunk,
// advertises the oldest full bank to the read side, and stalls upstream
// while the next target bank is still waiting to be consumed.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   s_valid_i/s_ready_o  upstream beat handshake
//   s_sparsemap_i        sparsemap bits of the beat
//   s_data_i             nonzero bytes, packed from byte 0
//   s_last_i             upstream end-of-chunk marker (checked, not obeyed)
//   wr_*_o               registered buffer write port (one-cycle strobe)
//   rd_release_i         read side finished bank rd_sel_o (one-cycle pulse)
//   rd_sel_o/rd_valid_o  oldest full bank and whether it is readable
//   rd_nz_count_o        nonzero element count of bank rd_sel_o
//   err_o                sticky protocol error, cleared only by reset
// ---------------------------------------------------------------------------
module ifm_chunk_wr_ctrl #(
    parameter  int BUS_SIZE       = 8,
    parameter  int CHUNK_SIZE     = 128,
    parameter  int WR_DAT_CYC_NUM = CHUNK_SIZE / BUS_SIZE,
    localparam int CNT_W          = (WR_DAT_CYC_NUM > 1) ? $clog2(WR_DAT_CYC_NUM) : 1,
    localparam int NZ_W           = $clog2(CHUNK_SIZE) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic [BUS_SIZE-1:0]     s_sparsemap_i,
    input  logic [BUS_SIZE*8-1:0]   s_data_i,
    input  logic                    s_last_i,
    output logic [BUS_SIZE-1:0]     wr_sparsemap_o,
    output logic [BUS_SIZE*8-1:0]   wr_nonzero_data_o,
    output logic                    wr_valid_o,
    output logic [CNT_W-1:0]        wr_count_o,
    output logic                    wr_sel_o,
    input  logic                    rd_release_i,
    output logic                    rd_sel_o,
    output logic                    rd_valid_o,
    output logic [NZ_W-1:0]         rd_nz_count_o,
    output logic                    err_o
);

    localparam int            PC_W     = $clog2(BUS_SIZE + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WR_DAT_CYC_NUM - 1);

    function automatic logic [PC_W-1:0] popcount(input logic [BUS_SIZE-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < BUS_SIZE; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    logic                  wr_bank,   wr_bank_n;
    logic [CNT_W-1:0]      beat_cnt,  beat_cnt_n;
    logic                  rd_bank,   rd_bank_n;
    logic [1:0]            full,      full_n;
    logic [1:0][NZ_W-1:0]  nz_cnt,    nz_cnt_n;
    logic                  done_r,    done_r_n;
    logic                  done_bank, done_bank_n;
    logic                  err,       err_n;

    logic                  accept;
    logic                  last_beat;
    logic [PC_W-1:0]       beat_pc;

    assign accept    = s_valid_i && s_ready_o;
    assign last_beat = (beat_cnt == LAST_CNT);
    assign beat_pc   = popcount(s_sparsemap_i);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours; blocking here would make
    // the result depend on statement order.
    // NOTE: nz_cnt is only two small registers, not a RAM, so it is reset
    // along with the rest; a real memory array would be left unreset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_bank   <= 1'b0;
            beat_cnt  <= '0;
            rd_bank   <= 1'b0;
            full      <= '0;
            nz_cnt    <= '0;
            done_r    <= 1'b0;
            done_bank <= 1'b0;
            err       <= 1'b0;
        end else begin
            wr_bank   <= wr_bank_n;
            beat_cnt  <= beat_cnt_n;
            rd_bank   <= rd_bank_n;
            full      <= full_n;
            nz_cnt    <= nz_cnt_n;
            done_r    <= done_r_n;
            done_bank <= done_bank_n;
            err       <= err_n;
        end
    end

    // Next-state logic.
    // NOTE: every variable gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_bank_n   = wr_bank;
        beat_cnt_n  = beat_cnt;
        rd_bank_n   = rd_bank;
        full_n      = full;
        nz_cnt_n    = nz_cnt;
        done_r_n    = 1'b0;
        done_bank_n = done_bank;
        err_n       = err;

        if (accept) begin
            if (last_beat) begin
                beat_cnt_n  = '0;
                wr_bank_n   = ~wr_bank;
                done_r_n    = 1'b1;
                done_bank_n = wr_bank;
            end else begin
                beat_cnt_n  = beat_cnt + CNT_W'(1);
            end

            // s_last_i is only cross-checked; the beat counter defines framing.
            if (s_last_i != last_beat) begin
                err_n = 1'b1;
            end

            // First beat of a chunk restarts the bank's nonzero count.
            if (beat_cnt == '0) begin
                nz_cnt_n[wr_bank] = NZ_W'(beat_pc);
            end else begin
                nz_cnt_n[wr_bank] = nz_cnt[wr_bank] + NZ_W'(beat_pc);
            end
        end

        if (rd_release_i) begin
            if (full[rd_bank]) begin
                full_n[rd_bank] = 1'b0;
                rd_bank_n       = ~rd_bank;
            end else begin
                err_n = 1'b1;
            end
        end

        // The full flag is raised one edge after the last write so the bank
        // is never advertised before its final beat has landed in the buffer.
        // Applied after the release so a same-bank collision keeps it full.
        if (done_r) begin
            full_n[done_bank] = 1'b1;
        end
    end

    // Outputs derived from registers only; s_ready_o never looks at s_valid_i.
    always_comb begin
        s_ready_o     = !full[wr_bank] && !(done_r && (done_bank == wr_bank));
        rd_sel_o      = rd_bank;
        rd_valid_o    = full[rd_bank];
        rd_nz_count_o = nz_cnt[rd_bank];
        err_o         = err;
    end

    // -----------------------------------------------------------------------
    // Registered buffer write port
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_valid_o        <= 1'b0;
            wr_count_o        <= '0;
            wr_sel_o          <= 1'b0;
            wr_sparsemap_o    <= '0;
            wr_nonzero_data_o <= '0;
        end else begin
            wr_valid_o <= accept;
            if (accept) begin
                wr_count_o        <= beat_cnt;
                wr_sel_o          <= wr_bank;
                wr_sparsemap_o    <= s_sparsemap_i;
                wr_nonzero_data_o <= s_data_i;
            end
        end
    end

endmodule

// File: tb/tb_ifm_chunk_wr_ctrl.sv
module tb_ifm_chunk_wr_ctrl;

    localparam int BUS   = 8;
    localparam int CHUNK = 128;
    localparam int BEATS = CHUNK / BUS;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              s_valid_i;
    logic              s_ready_o;
    logic [BUS-1:0]    s_sparsemap_i;
    logic [BUS*8-1:0]  s_data_i;
    logic              s_last_i;
    logic [BUS-1:0]    wr_sparsemap_o;
    logic [BUS*8-1:0]  wr_nonzero_data_o;
    logic              wr_valid_o;
    logic [3:0]        wr_count_o;
    logic              wr_sel_o;
    logic              rd_release_i;
    logic              rd_sel_o;
    logic              rd_valid_o;
    logic [7:0]        rd_nz_count_o;
    logic              err_o;

    ifm_chunk_wr_ctrl #(.BUS_SIZE(BUS), .CHUNK_SIZE(CHUNK)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .s_valid_i        (s_valid_i),
        .s_ready_o        (s_ready_o),
        .s_sparsemap_i    (s_sparsemap_i),
        .s_data_i         (s_data_i),
        .s_last_i         (s_last_i),
        .wr_sparsemap_o   (wr_sparsemap_o),
        .wr_nonzero_data_o(wr_nonzero_data_o),
        .wr_valid_o       (wr_valid_o),
        .wr_count_o       (wr_count_o),
        .wr_sel_o         (wr_sel_o),
        .rd_release_i     (rd_release_i),
        .rd_sel_o         (rd_sel_o),
        .rd_valid_o       (rd_valid_o),
        .rd_nz_count_o    (rd_nz_count_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [BUS-1:0] smap;
        int             exp_nz;
    } vec_t;

    typedef struct {
        logic [BUS-1:0]   smap;
        logic [BUS*8-1:0] data;
        logic [3:0]       cnt;
        logic             sel;
    } beat_t;

    beat_t sb[$];
    vec_t  vecs[6];

    int n_checks = 0;
    int n_err    = 0;
    int stalls   = 0;
    int m_cnt    = 0;
    bit m_bank   = 1'b0;
    bit m_rd     = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every write strobe must match the oldest accepted beat.
    always @(negedge clk_i) begin
        beat_t e;
        if (rst_ni && wr_valid_o) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_write", 1, 0);
            end else begin
                e = sb.pop_front();
                check("wr_count",     64'(wr_count_o),        64'(e.cnt));
                check("wr_sel",       64'(wr_sel_o),          64'(e.sel));
                check("wr_sparsemap", 64'(wr_sparsemap_o),    64'(e.smap));
                check("wr_data",      wr_nonzero_data_o,      e.data);
            end
        end
    end

    // Entry/exit point of every task below: 1 time unit after a rising edge.
    task automatic send_beat(input logic [BUS-1:0] sm, input bit last);
        int w;
        logic [BUS*8-1:0] d;
        d = {$urandom, $urandom};
        s_valid_i     = 1'b1;
        s_sparsemap_i = sm;
        s_data_i      = d;
        s_last_i      = last;
        @(negedge clk_i);
        w = 0;
        while (!s_ready_o && w < 50) begin
            @(negedge clk_i);
            w++;
        end
        stalls += w;
        if (!s_ready_o) begin
            check("ready_timeout", 0, 1);
        end else begin
            sb.push_back('{smap: sm, data: d, cnt: 4'(m_cnt), sel: m_bank});
            if (m_cnt == BEATS - 1) begin
                m_cnt  = 0;
                m_bank = ~m_bank;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk_i);
        #1;
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic send_chunk(input logic [BUS-1:0] sm);
        for (int i = 0; i < BEATS; i++) begin
            send_beat(sm, i == BEATS - 1);
        end
    endtask

    task automatic pulse_release(input bit expect_valid);
        rd_release_i = 1'b1;
        @(posedge clk_i);
        #1;
        rd_release_i = 1'b0;
        if (expect_valid) m_rd = ~m_rd;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni       = 1'b0;
        s_valid_i    = 1'b0;
        s_last_i     = 1'b0;
        rd_release_i = 1'b0;
        sb.delete();
        m_cnt  = 0;
        m_bank = 1'b0;
        m_rd   = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        s_sparsemap_i = '0;
        s_data_i      = '0;
        do_reset();

        // Reset state
        check("rst_wr_valid",  64'(wr_valid_o),        0);
        check("rst_wr_count",  64'(wr_count_o),        0);
        check("rst_wr_sel",    64'(wr_sel_o),          0);
        check("rst_wr_smap",   64'(wr_sparsemap_o),    0);
        check("rst_wr_data",   wr_nonzero_data_o,      0);
        check("rst_rd_sel",    64'(rd_sel_o),          0);
        check("rst_rd_valid",  64'(rd_valid_o),        0);
        check("rst_rd_nz",     64'(rd_nz_count_o),     0);
        check("rst_err",       64'(err_o),             0);
        check("rst_s_ready",   64'(s_ready_o),         1);

        // Table: one chunk per sparsemap pattern, released after each
        vecs[0] = '{smap: 8'hFF, exp_nz: 128};
        vecs[1] = '{smap: 8'h01, exp_nz: 16};
        vecs[2] = '{smap: 8'h00, exp_nz: 0};
        vecs[3] = '{smap: 8'hA5, exp_nz: 64};
        vecs[4] = '{smap: 8'h80, exp_nz: 16};
        vecs[5] = '{smap: 8'h7F, exp_nz: 112};
        for (int v = 0; v < 6; v++) begin
            send_chunk(vecs[v].smap);
            check("tbl_rd_valid_before_full", 64'(rd_valid_o), 0);
            tick();
            check("tbl_rd_valid",  64'(rd_valid_o),    1);
            check("tbl_rd_sel",    64'(rd_sel_o),      64'(m_rd));
            check("tbl_rd_nz",     64'(rd_nz_count_o), 64'(vecs[v].exp_nz));
            check("tbl_wr_idle",   64'(wr_valid_o),    0);
            check("tbl_err",       64'(err_o),         0);
            pulse_release(1'b1);
            check("tbl_rd_valid_released", 64'(rd_valid_o), 0);
            check("tbl_rd_sel_toggled",    64'(rd_sel_o),   64'(m_rd));
        end
        check("tbl_no_stall", 64'(stalls), 0);

        // Two chunks without release: bank 0 then bank 1 back-to-back
        send_chunk(8'h03);
        send_chunk(8'h0F);
        check("bb_no_bubble",        64'(stalls),        0);
        check("bb_ready_low",        64'(s_ready_o),     0);
        tick();
        tick();
        check("bb_rd_valid",         64'(rd_valid_o),    1);
        check("bb_rd_sel",           64'(rd_sel_o),      0);
        check("bb_rd_nz",            64'(rd_nz_count_o), 32);
        check("bb_ready_still_low",  64'(s_ready_o),     0);
        pulse_release(1'b1);
        check("bb_rel_rd_sel",       64'(rd_sel_o),      1);
        check("bb_rel_ready",        64'(s_ready_o),     1);
        check("bb_rel_rd_valid",     64'(rd_valid_o),    1);
        check("bb_rel_rd_nz",        64'(rd_nz_count_o), 64);
        send_chunk(8'h01);               // third chunk lands in bank 0
        tick();
        check("bb3_ready_low",       64'(s_ready_o),     0);
        pulse_release(1'b1);
        check("bb3_rd_sel",          64'(rd_sel_o),      0);
        check("bb3_rd_nz",           64'(rd_nz_count_o), 16);
        pulse_release(1'b1);
        check("bb3_empty",           64'(rd_valid_o),    0);

        // Release of one bank on the same edge the other becomes full
        send_chunk(8'hFF);               // bank 1
        tick();
        pulse_release(1'b1);             // bank 1 freed, reader now on bank 0
        send_chunk(8'h11);               // bank 0, 32 nonzeros
        tick();
        send_chunk(8'h07);               // bank 1, 48 nonzeros
        pulse_release(1'b1);             // sampled on the bank-1 full-set edge
        check("same_edge_rd_sel",    64'(rd_sel_o),      1);
        check("same_edge_rd_valid",  64'(rd_valid_o),    1);
        check("same_edge_rd_nz",     64'(rd_nz_count_o), 48);
        check("same_edge_ready",     64'(s_ready_o),     1);
        check("same_edge_err",       64'(err_o),         0);
        tick();
        check("same_edge_hold",      64'(rd_valid_o),    1);
        pulse_release(1'b1);
        check("same_edge_drained",   64'(rd_valid_o),    0);

        // s_last_i on beat 7: error flagged, framing unchanged
        for (int i = 0; i < BEATS; i++) begin
            send_beat(8'hFF, (i == 7) || (i == BEATS - 1));
            if (i == 6) check("early_last_err_before", 64'(err_o), 0);
            if (i == 7) check("early_last_err_set",    64'(err_o), 1);
        end
        tick();
        check("early_last_rd_valid", 64'(rd_valid_o),    1);
        check("early_last_rd_nz",    64'(rd_nz_count_o), 128);
        check("early_last_rd_sel",   64'(rd_sel_o),      0);

        // Asynchronous reset in the middle of a chunk (after beat 5)
        for (int i = 0; i < 6; i++) send_beat(8'h0F, 1'b0);
        #1;
        rst_ni = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_wr_valid",  64'(wr_valid_o),    0);
        check("mid_rst_wr_count",  64'(wr_count_o),    0);
        check("mid_rst_wr_sel",    64'(wr_sel_o),      0);
        check("mid_rst_rd_valid",  64'(rd_valid_o),    0);
        check("mid_rst_rd_nz",     64'(rd_nz_count_o), 0);
        check("mid_rst_err",       64'(err_o),         0);
        check("mid_rst_ready",     64'(s_ready_o),     1);
        do_reset();

        // Release with nothing full
        pulse_release(1'b0);
        check("bad_release_err",    64'(err_o),    1);
        check("bad_release_rd_sel", 64'(rd_sel_o), 0);
        do_reset();

        // Fresh chunk after reset restarts at count 0, bank 0
        send_chunk(8'h3C);
        tick();
        check("post_rst_rd_valid", 64'(rd_valid_o),    1);
        check("post_rst_rd_nz",    64'(rd_nz_count_o), 64);
        check("post_rst_rd_sel",   64'(rd_sel_o),      0);
        check("post_rst_err",      64'(err_o),         0);

        repeat (2) tick();
        check("sb_drained", 64'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ifm_chunk_wr_ctrl.md
# ifm_chunk_wr_ctrl

Write-side controller for the ping-pong IFM chunk buffer. Accepts a valid/ready stream of compressed IFM beats (sparsemap + packed nonzero bytes), registers them onto the buffer's write port with a beat count, and steers each chunk to bank 0 or 1. Tracks per-bank fill state, advertises full banks to the read side, and stalls upstream when the target bank is still being consumed. Sits directly upstream of the dual-bank chunk stacking stage.

## Interface
- BUS_SIZE, 8: sparsemap bits / bytes per beat.
- CHUNK_SIZE, 128: elements per chunk; multiple of BUS_SIZE.
- WR_DAT_CYC_NUM, CHUNK_SIZE/BUS_SIZE: derived beats per chunk; must be at least 2.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- s_valid_i  in  1  upstream beat valid.
- s_ready_o  out  1  beat accepted when s_valid_i && s_ready_o.
- s_sparsemap_i  in  BUS_SIZE  sparsemap bits of the beat.
- s_data_i  in  BUS_SIZE x 8  nonzero bytes, packed from index 0.
- s_last_i  in  1  upstream marks final beat of chunk.
- wr_sparsemap_o  out  BUS_SIZE  registered sparsemap to buffer.
- wr_nonzero_data_o  out  BUS_SIZE x 8  registered data to buffer.
- wr_valid_o  out  1  buffer write strobe.
- wr_count_o  out  clog2(WR_DAT_CYC_NUM)  beat index within chunk.
- wr_sel_o  out  1  target bank of the current write.
- rd_release_i  in  1  single-cycle pulse: read side finished bank rd_sel_o.
- rd_sel_o  out  1  oldest full bank (bank the reader uses next).
- rd_valid_o  out  1  rd_sel_o bank is full and readable.
- rd_nz_count_o  out  clog2(CHUNK_SIZE)+1  nonzero count of bank rd_sel_o.
- err_o  out  1  sticky protocol error.

## Operation
- Per-bank state: EMPTY -> FILLING (first beat accepted) -> FULL (last beat written) -> EMPTY (rd_release_i on that bank).
- Registers: wr_bank (0 at reset), beat_cnt, rd_bank (0 at reset), full[1:0], nz_cnt[1:0], done_r, err.
- s_ready_o = !full[wr_bank] && !(done_r && done bank == wr_bank); combinational from registers only, never from s_valid_i.
- On accept: output registers load sparsemap/data, wr_count_o <= beat_cnt, wr_sel_o <= wr_bank, wr_valid_o <= 1; nz_cnt[wr_bank] += popcount(s_sparsemap_i) (cleared on first beat: loaded rather than added when beat_cnt == 0).
- beat_cnt increments per accept; on beat_cnt == WR_DAT_CYC_NUM-1: beat_cnt <= 0, wr_bank toggles, done_r <= 1 with bank recorded.
- done_r set: full[done bank] <= 1 next edge; done_r clears.
- rd_release_i with rd_valid_o = 1: full[rd_bank] <= 0, rd_bank toggles. Without rd_valid_o: ignored, err <= 1.
- Release and full-set on the same edge address different banks or the same bank; full-set wins only for its bank, release for its own; both apply.
- s_last_i asserted on beat_cnt != WR_DAT_CYC_NUM-1, or deasserted on the final beat: err <= 1; counting is never altered by s_last_i.
- rd_nz_count_o = nz_cnt[rd_bank]; value range 0..CHUNK_SIZE.
- err_o cleared only by reset.

## Timing
- Reset (async assert, sync-safe deassert): wr_valid_o=0, wr_count_o=0, wr_sel_o=0, wr_sparsemap_o=0, wr_nonzero_data_o=0, rd_sel_o=0, rd_valid_o=0, rd_nz_count_o=0, err_o=0, s_ready_o=1 after reset (both banks EMPTY). Reset mid-chunk discards partial chunk and all full flags.
- Accept at edge T -> wr_valid_o high for cycle T..T+1; buffer writes at edge T+1.
- Last beat accepted at T -> full set at T+1 (after data written) -> rd_valid_o high from T+1. Chunk latency: WR_DAT_CYC_NUM+1 cycles from first accept at full rate.
- Throughput: one beat per cycle while the target bank is not FULL; back-to-back chunks to alternating banks with no bubble.
- Both banks FULL: s_ready_o=0 until a release; release at edge R makes s_ready_o=1 in cycle R..R+1.
- wr_valid_o is a one-cycle pulse per accepted beat; no output-side backpressure.

## Test plan
- Reset, stream 16 beats of all-ones sparsemap (BUS=8, CHUNK=128), no stall -> wr_count_o 0..15 with wr_sel_o=0, rd_valid_o rises one cycle after last wr_valid_o, rd_nz_count_o=128.
- Stream two chunks with no release -> second chunk on wr_sel_o=1, s_ready_o=0 after 32nd beat; release pulse -> rd_sel_o=1, s_ready_o=1 next cycle, third chunk writes bank 0.
- Sparsemap 0x01 every beat -> rd_nz_count_o=16; sparsemap 0x00 -> 0.
- s_last_i on beat 7 of 16 -> err_o=1 at next cycle, chunk still completes at beat 15; rd_release_i with rd_valid_o=0 -> err_o=1.
- Release of bank 0 on the same edge bank 1 becomes full -> full=2'b10, rd_sel_o=1, rd_valid_o=1.
- Assert rst_ni low mid-chunk (beat 5) -> all outputs reset asynchronously; next chunk starts at wr_count_o=0, bank 0.
